// File: rtl/fa_stage_pkg.sv
// Shared constants and helpers for the staging BRAM write-side controller.
package fa_stage_pkg;

  localparam int unsigned BLOCK_SIZE      = 128;
  localparam int unsigned BUFFER_HEADROOM = 20;
  localparam int unsigned STAGE_DEPTH     = 8192;

  // Highest occupancy at which the host may still start a full block:
  // room for one block plus slack for the occupancy count latency.
  function automatic int unsigned ready_threshold(input int unsigned depth,
                                                  input int unsigned headroom,
                                                  input int unsigned block);
    return depth - headroom - block;
  endfunction

endpackage

// File: rtl/stage_chan.sv
// One staging channel: write address, occupancy, throttle and sticky error flags.
module stage_chan
  import fa_stage_pkg::*;
#(
  parameter int unsigned DEPTH    = STAGE_DEPTH,
  parameter int unsigned AW       = 13,
  parameter int unsigned BLOCK    = BLOCK_SIZE,
  parameter int unsigned HEADROOM = BUFFER_HEADROOM
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          mode_wrap,
  input  logic          wr_en,
  input  logic          rd_release,
  output logic [AW-1:0] wr_addr,
  output logic [AW:0]   occ,
  output logic          ready,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic          unf
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] THRESH  = (AW+1)'(ready_threshold(DEPTH, HEADROOM, BLOCK));

  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          ready_q, ready_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_accept, wr_drop, rel_ok, rel_bad;

  // Next-state: clear wins; otherwise accept/drop writes, apply ring releases,
  // and derive the flags from the next occupancy so they stay coherent with it.
  always_comb begin
    wr_accept = wr_en & ~full_q;
    wr_drop   = wr_en & full_q;
    rel_ok    = mode_wrap & rd_release & ~empty_q;
    rel_bad   = mode_wrap & rd_release & empty_q;
    addr_d    = addr_q;
    occ_d     = occ_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    if (clr) begin
      addr_d = '0;
      occ_d  = '0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
    end else begin
      if (wr_accept) addr_d = addr_q + AW'(1);
      if (wr_drop)   ovf_d  = 1'b1;
      if (rel_bad)   unf_d  = 1'b1;
      case ({wr_accept, rel_ok})
        2'b10:   occ_d = occ_q + (AW+1)'(1);
        2'b01:   occ_d = occ_q - (AW+1)'(1);
        default: occ_d = occ_q;
      endcase
    end
    ready_d = (occ_d <= THRESH);
    full_d  = (occ_d == DEPTH_W);
    empty_d = (occ_d == '0);
  end

  // Channel state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      occ_q   <= '0;
      ready_q <= 1'b1;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      occ_q   <= occ_d;
      ready_q <= ready_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign wr_addr = addr_q;
  assign occ     = occ_q;
  assign ready   = ready_q;
  assign full    = full_q;
  assign empty   = empty_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;

endmodule

// File: rtl/bram_stage_ctrl.sv
// Write-side controller for the staging BRAMs: NCH independent channel slices
// with their addresses and occupancies packed onto flat buses.
module bram_stage_ctrl
  import fa_stage_pkg::*;
#(
  parameter int unsigned NCH      = 2,
  parameter int unsigned DEPTH    = STAGE_DEPTH,
  parameter int unsigned AW       = 13,
  parameter int unsigned BLOCK    = BLOCK_SIZE,
  parameter int unsigned HEADROOM = BUFFER_HEADROOM
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        clr,
  input  logic [NCH-1:0]        mode_wrap,
  input  logic [NCH-1:0]        wr_en,
  input  logic [NCH-1:0]        rd_release,
  output logic [NCH*AW-1:0]     wr_addr,
  output logic [NCH*(AW+1)-1:0] occ,
  output logic [NCH-1:0]        ready,
  output logic [NCH-1:0]        full,
  output logic [NCH-1:0]        empty,
  output logic [NCH-1:0]        ovf,
  output logic [NCH-1:0]        unf
);

  // One independent counter/flag slice per channel.
  for (genvar c = 0; c < NCH; c++) begin : g_chan
    stage_chan #(
      .DEPTH    (DEPTH),
      .AW       (AW),
      .BLOCK    (BLOCK),
      .HEADROOM (HEADROOM)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr[c]),
      .mode_wrap  (mode_wrap[c]),
      .wr_en      (wr_en[c]),
      .rd_release (rd_release[c]),
      .wr_addr    (wr_addr[c*AW +: AW]),
      .occ        (occ[c*(AW+1) +: (AW+1)]),
      .ready      (ready[c]),
      .full       (full[c]),
      .empty      (empty[c]),
      .ovf        (ovf[c]),
      .unf        (unf[c])
    );
  end

endmodule

// File: tb/tb_bram_stage_ctrl.sv
// Directed scoreboard bench for bram_stage_ctrl (NCH=2, DEPTH=8192, threshold 8044).
module tb_bram_stage_ctrl;

  localparam int NCH = 2, DEPTH = 8192, AW = 13, BLOCK = 128, HEADROOM = 20;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NCH-1:0]        clr = '0;
  logic [NCH-1:0]        mode_wrap = 2'b10;
  logic [NCH-1:0]        wr_en = '0;
  logic [NCH-1:0]        rd_release = '0;
  logic [NCH*AW-1:0]     wr_addr;
  logic [NCH*(AW+1)-1:0] occ;
  logic [NCH-1:0]        ready, full, empty, ovf, unf;

  bram_stage_ctrl #(
    .NCH(NCH), .DEPTH(DEPTH), .AW(AW), .BLOCK(BLOCK), .HEADROOM(HEADROOM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .mode_wrap(mode_wrap),
    .wr_en(wr_en), .rd_release(rd_release), .wr_addr(wr_addr), .occ(occ),
    .ready(ready), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    int            ch;
    logic [AW-1:0] addr;
    logic [AW:0]   occ;
    logic [4:0]    flags;
  } exp_t;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Drive the given inputs for n clock edges; returns 1 time unit after the last edge.
  task automatic applyStimulus(input logic [1:0] w, input logic [1:0] r,
                               input logic [1:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = w; rd_release = r; clr = c;
      @(posedge clk); #1;
    end
    wr_en = '0; rd_release = '0; clr = '0;
  endtask

  // Queue an expected channel snapshot; flags are {ready,full,empty,ovf,unf}.
  task automatic checkOutput(input string name, input int ch, input int addr,
                             input int occv, input logic [4:0] flags);
    exp_t e;
    e.name = name; e.ch = ch; e.addr = AW'(addr); e.occ = (AW+1)'(occv); e.flags = flags;
    expQ.push_back(e);
  endtask

  // Monitor: on each falling edge, compare every pending expectation with the DUT.
  initial begin : monitor
    exp_t          e;
    logic [AW-1:0] a;
    logic [AW:0]   o;
    logic [4:0]    f;
    forever begin
      @(negedge clk);
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        a = wr_addr[e.ch*AW +: AW];
        o = occ[e.ch*(AW+1) +: (AW+1)];
        f = {ready[e.ch], full[e.ch], empty[e.ch], ovf[e.ch], unf[e.ch]};
        vectors++;
        if ({a, o, f} !== {e.addr, e.occ, e.flags}) begin
          miscompares++;
          $display("[TB] FAIL %s ch%0d: got addr=%0d occ=%0d rdy/full/empty/ovf/unf=%b, want addr=%0d occ=%0d flags=%b",
                   e.name, e.ch, a, o, f, e.addr, e.occ, e.flags);
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    miscompares++;
    $display("[TB] FAIL timeout: got no completion, want completion within budget");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Directed stimulus.
  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("reset_state", 0, 0, 0, 5'b10100);
    checkOutput("reset_state", 1, 0, 0, 5'b10100);

    // Asynchronous reset mid-stream.
    applyStimulus(2'b01, 2'b00, 2'b00, 5);
    applyStimulus(2'b10, 2'b00, 2'b00, 3);
    checkOutput("pre_reset", 0, 5, 5, 5'b10000);
    checkOutput("pre_reset", 1, 3, 3, 5'b10000);
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    checkOutput("async_reset", 0, 0, 0, 5'b10100);
    checkOutput("async_reset", 1, 0, 0, 5'b10100);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(2'b01, 2'b00, 2'b00, 1);
    checkOutput("first_write", 0, 1, 1, 5'b10000);
    checkOutput("ch1_untouched", 1, 0, 0, 5'b10100);

    // Linear fill on ch0 across the ready threshold, full and overflow.
    applyStimulus(2'b00, 2'b00, 2'b01, 1);
    applyStimulus(2'b01, 2'b00, 2'b00, 8044);
    checkOutput("fill_8044", 0, 8044, 8044, 5'b10000);
    applyStimulus(2'b01, 2'b00, 2'b00, 1);
    checkOutput("fill_8045", 0, 8045, 8045, 5'b00000);
    applyStimulus(2'b01, 2'b00, 2'b00, 146);
    checkOutput("fill_8191", 0, 8191, 8191, 5'b00000);
    applyStimulus(2'b01, 2'b00, 2'b00, 1);
    checkOutput("fill_full", 0, 0, 8192, 5'b01000);
    applyStimulus(2'b01, 2'b00, 2'b00, 1);
    checkOutput("fill_overflow", 0, 0, 8192, 5'b01010);

    // Linear mode ignores releases.
    applyStimulus(2'b00, 2'b00, 2'b01, 1);
    checkOutput("clr_after_ovf", 0, 0, 0, 5'b10100);
    applyStimulus(2'b01, 2'b00, 2'b00, 50);
    applyStimulus(2'b00, 2'b01, 2'b00, 100);
    checkOutput("linear_release", 0, 50, 50, 5'b10000);

    // Ring mode on ch1.
    applyStimulus(2'b10, 2'b00, 2'b00, 8192);
    checkOutput("ring_full", 1, 0, 8192, 5'b01000);
    applyStimulus(2'b00, 2'b10, 2'b00, 1);
    checkOutput("ring_release", 1, 0, 8191, 5'b00000);
    applyStimulus(2'b10, 2'b00, 2'b00, 1);
    checkOutput("ring_refill", 1, 1, 8192, 5'b01000);
    applyStimulus(2'b10, 2'b10, 2'b00, 1);
    checkOutput("ring_full_wr_rel", 1, 1, 8191, 5'b00010);
    applyStimulus(2'b00, 2'b00, 2'b10, 1);
    applyStimulus(2'b10, 2'b00, 2'b00, 100);
    checkOutput("ring_100", 1, 100, 100, 5'b10000);
    applyStimulus(2'b10, 2'b10, 2'b00, 1);
    checkOutput("ring_wr_rel", 1, 101, 100, 5'b10000);
    checkOutput("ch0_independent", 0, 50, 50, 5'b10000);

    // Ring underflow, sticky until clear.
    applyStimulus(2'b00, 2'b00, 2'b10, 1);
    applyStimulus(2'b00, 2'b10, 2'b00, 1);
    checkOutput("ring_underflow", 1, 0, 0, 5'b10101);
    applyStimulus(2'b10, 2'b00, 2'b00, 1);
    checkOutput("unf_sticky", 1, 1, 1, 5'b10001);
    applyStimulus(2'b00, 2'b00, 2'b10, 1);
    checkOutput("unf_cleared", 1, 0, 0, 5'b10100);

    // Clear wins over a simultaneous write.
    applyStimulus(2'b01, 2'b00, 2'b00, 250);
    checkOutput("occ_300", 0, 300, 300, 5'b10000);
    applyStimulus(2'b01, 2'b00, 2'b01, 1);
    checkOutput("clr_priority", 0, 0, 0, 5'b10100);

    applyStimulus(2'b00, 2'b00, 2'b00, 3);
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending expectations, want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
